// File: rtl/ex_stage.sv
// Execute stage: ALU, zero flag and branch target, registered as the EX/MEM boundary.
// Latency: single-cycle ops 1 cycle; MUL holds stall_out for 64 cycles and delivers on the 65th edge.
// Backpressure: stall_out (combinational) holds ID/EX during a multiply; flush kills the instruction and drops stall.
module ex_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             flush,
  input  logic [3:0]       alu_op,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] PC_out_in,
  input  logic [WIDTH-1:0] read_data1_in,
  input  logic [WIDTH-1:0] read_data2_in,
  input  logic [WIDTH-1:0] sign_extended_in,
  output logic             stall_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] alu_result_out,
  output logic             zero_out,
  output logic [WIDTH-1:0] PC_branch_out,
  output logic [WIDTH-1:0] read_data2_out
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_LSL  = 4'b0011;
  localparam logic [3:0] OP_LSR  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_nxt;
  logic [SHW-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] partial;

  logic [WIDTH-1:0] operand_b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_value;

  logic             load;
  logic             valid_nxt;
  logic [WIDTH-1:0] result_nxt;

  assign operand_b = alu_src ? sign_extended_in : read_data2_in;
  assign shamt     = sign_extended_in[SHW-1:0];

  // MUL is never produced here; it goes through the iterative path.
  always_comb begin
    alu_value = '0;
    case (alu_op)
      OP_AND:  alu_value = read_data1_in & operand_b;
      OP_OR:   alu_value = read_data1_in | operand_b;
      OP_ADD:  alu_value = read_data1_in + operand_b;
      OP_SUB:  alu_value = read_data1_in - operand_b;
      OP_PASS: alu_value = operand_b;
      OP_NOR:  alu_value = ~(read_data1_in | operand_b);
      OP_LSL:  alu_value = read_data1_in << shamt;
      OP_LSR:  alu_value = read_data1_in >> shamt;
      default: alu_value = '0;
    endcase
  end

  assign partial = mplier[cnt] ? (mcand << cnt) : '0;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    acc_nxt    = acc;
    stall_out  = 1'b0;
    load       = 1'b0;
    valid_nxt  = 1'b0;
    result_nxt = '0;

    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in && alu_op == OP_MUL) begin
            stall_out  = 1'b1;
            state_nxt  = BUSY;
            cnt_nxt    = '0;
            acc_nxt    = '0;
            mcand_nxt  = read_data1_in;
            mplier_nxt = operand_b;
          end else begin
            load       = 1'b1;
            valid_nxt  = valid_in;
            result_nxt = alu_value;
          end
        end
        BUSY: begin
          acc_nxt = acc + partial;
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            // ID/EX still holds the MUL, so PC and store data come straight from the inputs.
            load       = 1'b1;
            valid_nxt  = 1'b1;
            result_nxt = acc + partial;
            state_nxt  = IDLE;
          end else begin
            stall_out = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      acc    <= acc_nxt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_out      <= 1'b0;
      alu_result_out <= '0;
      zero_out       <= 1'b0;
      PC_branch_out  <= '0;
      read_data2_out <= '0;
    end else begin
      valid_out <= valid_nxt;
      if (load) begin
        alu_result_out <= result_nxt;
        zero_out       <= (result_nxt == '0);
        PC_branch_out  <= PC_out_in + (sign_extended_in << 2);
        read_data2_out <= read_data2_in;
      end
    end
  end

endmodule
